// File: rtl/mac_accumulator_64bits_if.sv
// Handshake bundle for mac_accumulator_64bits: block start, product stream and result return.
interface mac_accumulator_64bits_if #(
  parameter int unsigned LEN_W = 8
);
  localparam int unsigned DATA_W = 64;

  logic              start;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] product;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] sum;
  logic              sum_valid;
  logic              sum_ready;
  logic              busy;
  logic              overflow;

  modport master (
    output start, len, product, in_valid, sum_ready,
    input  in_ready, sum, sum_valid, busy, overflow
  );

  modport slave (
    input  start, len, product, in_valid, sum_ready,
    output in_ready, sum, sum_valid, busy, overflow
  );
endinterface

// File: rtl/mac_accumulator_64bits.sv
// Accumulates a block of len unsigned 64-bit products and returns the sum with a sticky carry flag.
// Optional macro ACC_SATURATE_EN clamps the sum to all-ones on carry instead of wrapping.
module mac_accumulator_64bits #(
  parameter int unsigned LEN_W = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  mac_accumulator_64bits_if.slave bus
);
  localparam int unsigned DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state;
  state_e            state_nxt;
  logic [DATA_W-1:0] acc;
  logic [LEN_W-1:0]  cnt;
  logic              ovf;
  logic              in_ready_r;
  logic              sum_valid_r;
  logic              busy_r;
  logic              in_ready_nxt;
  logic              sum_valid_nxt;
  logic              busy_nxt;
  logic              start_c;
  logic              accept_c;
  logic [DATA_W:0]   add_c;

  assign start_c  = (state == IDLE) && bus.start;
  assign accept_c = (state == ACC) && bus.in_valid;
  assign add_c    = {1'b0, acc} + {1'b0, bus.product};

  // State register; status outputs are registered from their next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_r  <= 1'b0;
      sum_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_r  <= in_ready_nxt;
      sum_valid_r <= sum_valid_nxt;
      busy_r      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.len == '0) ? DONE : ACC;
      ACC:  if (bus.in_valid && (cnt == LEN_W'(1))) state_nxt = DONE;
      DONE: if (bus.sum_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_nxt  = 1'b0;
    sum_valid_nxt = 1'b0;
    busy_nxt      = 1'b0;
    case (state_nxt)
      ACC: begin
        in_ready_nxt = 1'b1;
        busy_nxt     = 1'b1;
      end
      DONE: begin
        sum_valid_nxt = 1'b1;
        busy_nxt      = 1'b1;
      end
      default: ;
    endcase
  end

  // Accumulator, remaining-beat count and sticky carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (start_c) begin
      acc <= '0;
      cnt <= bus.len;
      ovf <= 1'b0;
    end else if (accept_c) begin
`ifdef ACC_SATURATE_EN
      acc <= (ovf || add_c[DATA_W]) ? '1 : add_c[DATA_W-1:0];
`else
      acc <= add_c[DATA_W-1:0];
`endif
      cnt <= cnt - LEN_W'(1);
      ovf <= ovf | add_c[DATA_W];
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.sum_valid = sum_valid_r;
  assign bus.busy      = busy_r;
  assign bus.sum       = acc;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_mac_accumulator_64bits.sv
// Randomized bench for mac_accumulator_64bits against a block-total reference model.
module tb_mac_accumulator_64bits;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  logic [63:0] pv [16];

  // Reference model: spec phases plus the exact (unbounded) block total.
  int          m_phase = 0;
  int          m_cnt = 0;
  logic [71:0] m_total = '0;

  mac_accumulator_64bits_if #(.LEN_W(8)) bus ();

  mac_accumulator_64bits #(.LEN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] exp_acc(input logic [71:0] t);
`ifdef ACC_SATURATE_EN
    return (t[71:64] != 8'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : t[63:0];
`else
    return t[63:0];
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_cnt   = 0;
      m_total = '0;
    end else begin
      case (m_phase)
        0: if (bus.start) begin
          m_total = '0;
          if (bus.len == 8'd0) m_phase = 2;
          else begin
            m_cnt   = int'(bus.len);
            m_phase = 1;
          end
        end
        1: if (bus.in_valid) begin
          m_total = m_total + {8'd0, bus.product};
          m_cnt   = m_cnt - 1;
          if (m_cnt == 0) m_phase = 2;
        end
        default: if (bus.sum_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  64'(bus.in_ready),  64'(m_phase == 1));
      chk("sum_valid", 64'(bus.sum_valid), 64'(m_phase == 2));
      chk("busy",      64'(bus.busy),      64'(m_phase != 0));
      chk("sum",       bus.sum,            exp_acc(m_total));
      chk("overflow",  64'(bus.overflow),  64'(m_total[71:64] != 8'd0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd_prod();
    case ($urandom_range(0, 2))
      0:       return 64'($urandom_range(0, 1000));
      1:       return {32'($urandom), 32'($urandom)};
      default: return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 50));
    endcase
  endfunction

  task automatic run_block(input int n, input int gmin, input int gmax, input int hold,
                           input bit lit, input logic [63:0] esum, input logic eovf);
    bus.start = 1'b1;
    bus.len   = 8'(n);
    tick();
    bus.start = 1'b0;
    if (lit && n == 0) begin
      chk("len0 sum_valid", 64'(bus.sum_valid), 64'd1);
      chk("len0 in_ready",  64'(bus.in_ready),  64'd0);
      chk("len0 sum",       bus.sum,            64'd0);
    end
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gmin, gmax)) begin
        bus.in_valid = 1'b0;
        bus.product  = rnd_prod();
        bus.start    = 1'($urandom_range(0, 1));
        bus.len      = 8'($urandom_range(0, 255));
        tick();
      end
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.product  = pv[i];
      tick();
      bus.in_valid = 1'b0;
      bus.product  = rnd_prod();
    end
    if (lit) begin
      chk("done sum_valid", 64'(bus.sum_valid), 64'd1);
      chk("done sum",       bus.sum,            esum);
      chk("done overflow",  64'(bus.overflow),  64'(eovf));
    end
    repeat (hold) begin
      bus.sum_ready = 1'b0;
      bus.start     = 1'($urandom_range(0, 1));
      tick();
    end
    if (lit && hold > 0) chk("held sum", bus.sum, esum);
    bus.sum_ready = 1'b1;
    bus.start     = 1'b1;
    tick();
    bus.sum_ready = 1'b0;
    bus.start     = 1'b0;
    if (lit) chk("post handshake sum_valid", 64'(bus.sum_valid), 64'd0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.product   = '0;
    bus.in_valid  = 1'b0;
    bus.sum_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset sum",       bus.sum,            64'd0);
    chk("reset sum_valid", 64'(bus.sum_valid), 64'd0);
    chk("reset busy",      64'(bus.busy),      64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Three consecutive beats.
    pv[0] = 64'd5; pv[1] = 64'd7; pv[2] = 64'd9;
    run_block(3, 0, 0, 0, 1'b1, 64'h15, 1'b0);

    // Carry out of the 64-bit adder.
    pv[0] = 64'hFFFF_FFFF_FFFF_FFFF; pv[1] = 64'd2;
`ifdef ACC_SATURATE_EN
    run_block(2, 0, 0, 1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
`else
    run_block(2, 0, 0, 1, 1'b1, 64'h1, 1'b1);
`endif

    // Empty block.
    run_block(0, 0, 0, 0, 1'b1, 64'd0, 1'b0);

    // Gaps of three idle cycles and a stalled consumer.
    pv[0] = 64'h1_0000_0001; pv[1] = 64'h22;
    run_block(2, 3, 3, 5, 1'b1, 64'h1_0000_0023, 1'b0);

    // Reset after one of four beats.
    bus.start = 1'b1;
    bus.len   = 8'd4;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.product  = 64'h77;
    tick();
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset sum",       bus.sum,            64'd0);
    chk("mid reset sum_valid", 64'(bus.sum_valid), 64'd0);
    chk("mid reset in_ready",  64'(bus.in_ready),  64'd0);
    chk("mid reset busy",      64'(bus.busy),      64'd0);
    chk("mid reset overflow",  64'(bus.overflow),  64'd0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) tick();
    pv[0] = 64'h1234;
    run_block(1, 0, 0, 0, 1'b1, 64'h1234, 1'b0);

    for (int b = 0; b < 60; b++) begin
      int n;
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) pv[i] = rnd_prod();
      run_block(n, 0, 3, $urandom_range(0, 5), 1'b0, 64'd0, 1'b0);
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_accumulator_64bits.md
MAC_ACCUMULATOR_64BITS -- requirements
Module: mac_accumulator_64bits

Interface
REQ-001 The block SHALL have one parameter: LEN_W, default 8, width of the block-length input.
REQ-002 The block SHALL have a single clock; reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin one accumulation block; sampled only in IDLE.
REQ-006 len  input  LEN_W  number of products in the block, latched when start is accepted.
REQ-007 product  input  64  unsigned 64-bit product from the upstream 32x32 multiplier.
REQ-008 in_valid  input  1  product is valid this cycle.
REQ-009 in_ready  output  1  block accepts product this cycle.
REQ-010 sum  output  64  accumulated result.
REQ-011 sum_valid  output  1  sum is valid and held.
REQ-012 sum_ready  input  1  downstream accepts sum.
REQ-013 busy  output  1  high in ACC and DONE.
REQ-014 overflow  output  1  an accumulation carry-out occurred in the current block; valid with sum.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-016 IDLE with start=1 and len!=0: latch len into the remaining-count register, clear acc and overflow, and go to ACC on the next edge.
REQ-017 IDLE with start=1 and len=0: clear acc and overflow, and go directly to DONE, giving sum=0.
REQ-018 in_ready SHALL be 1 only in ACC; a beat is accepted when in_valid=1 and in_ready=1 on a rising edge.
REQ-019 Each accepted beat SHALL add product to acc (unsigned, 64-bit) and decrement the remaining count by 1.
REQ-020 Cycles with in_valid=0 in ACC SHALL leave acc and the count unchanged, with no timeout.
REQ-021 When the beat with count=1 is accepted, the FSM SHALL enter DONE, and sum_valid SHALL be 1 in the following cycle (latency: 1 cycle after the last accept).
REQ-022 DONE: sum_valid=1, and sum and overflow SHALL be held stable until sum_valid=1 and sum_ready=1 on a rising edge; the FSM then returns to IDLE.
REQ-023 sum SHALL equal the acc register at all times; sum_valid SHALL be 0 outside DONE.
REQ-024 start SHALL be ignored in ACC and DONE; a start in the same cycle as the DONE handshake SHALL be ignored (accepted only once in IDLE).
REQ-025 overflow SHALL be sticky within a block and set on any 65th-bit carry of an addition.
REQ-026 len and product changes outside acceptance SHALL have no effect.

Reset
REQ-027 rst_n=0 SHALL immediately force: state=IDLE, acc=0, count=0, sum=0, sum_valid=0, in_ready=0, busy=0, overflow=0.
REQ-028 Reset asserted mid-block (ACC or DONE) SHALL discard the partial result; no sum_valid SHALL be produced for that block after reset release.
REQ-029 After rst_n deasserts, the first start SHALL be accepted no earlier than the first rising edge with rst_n=1.

Configuration
REQ-030 Macro ACC_SATURATE_EN: when defined, an addition with carry-out SHALL set acc to 64'hFFFF_FFFF_FFFF_FFFF and keep it there for the rest of the block; overflow SHALL be set.
REQ-031 Without ACC_SATURATE_EN, acc SHALL wrap modulo 2^64 (the low 64 bits of the sum are kept); overflow SHALL still be set.

Verification
REQ-032 len=3, products 5, 7, 9 on consecutive cycles with in_valid=1 -> sum=64'h15, overflow=0, sum_valid=1 one cycle after the 3rd accept.
REQ-033 len=2, products 64'hFFFF_FFFF_FFFF_FFFF then 2 -> without macro sum=64'h1 and overflow=1; with ACC_SATURATE_EN sum=64'hFFFF_FFFF_FFFF_FFFF and overflow=1.
REQ-034 start with len=0 -> next cycle DONE, sum=0, sum_valid=1, in_ready never 1.
REQ-035 len=2 with in_valid gaps of 3 cycles and sum_ready held 0 for 5 cycles in DONE -> sum=product0+product1 held constant, in_ready=0, and start pulses ignored until the handshake.
REQ-036 rst_n pulsed low after 1 of 4 beats -> all outputs 0 immediately; a new block with len=1 and product=64'h1234 gives sum=64'h1234.
